regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_arb_pkg.sv | 27 ++
 rtl/mc_result_fifo.sv | 59 +++++
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared widths, defaults and payload types for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned NUM_REGS         = 1 << REG_ADDR_W;
  localparam int unsigned DEF_FIFO_DEPTH   = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned STARVE_CNT_W     = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } mc_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_FIFO = 2'd2
  } grant_e;

  // Register 0 is hardwired; writes to it are consumed but never committed.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] r);
    return r == '0;
  endfunction

endpackage

// File: rtl/mc_result_fifo.sv
// Small synchronous FIFO buffering multi-cycle results until they win the write port.
module mc_result_fifo
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  mc_entry_t wdata,
  output mc_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  mc_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy state; reset drops any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and buffered
// multi-cycle results, with starvation protection and a pending-destination scoreboard.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_stall,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_reg,
  input  logic [DATA_W-1:0]     mc_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  input  logic [REG_ADDR_W-1:0] rd_reg1,
  input  logic [REG_ADDR_W-1:0] rd_reg2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wreg,
  output logic [DATA_W-1:0]     rf_wdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  mc_entry_t                fifo_in;
  mc_entry_t                fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  grant_e                   grant;
  logic [STARVE_CNT_W-1:0]  starve_cnt;
  logic [STARVE_CNT_W-1:0]  starve_cnt_nxt;
  logic [NUM_REGS-1:0]      pending;
  logic [NUM_REGS-1:0]      pending_nxt;

  assign mc_ready  = rst_n && !fifo_full;
  assign fifo_push = mc_valid && mc_ready;
  assign fifo_in   = '{rd: mc_reg, data: mc_data};

  mc_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Priority: starved FIFO head, then WB, then FIFO head when WB is idle.
  always_comb begin
    grant = GRANT_NONE;
    if (!rst_n) begin
      grant = GRANT_NONE;
    end else if ((starve_cnt == STARVE_MAX) && !fifo_empty) begin
      grant = GRANT_FIFO;
    end else if (wb_we) begin
      grant = GRANT_WB;
    end else if (!fifo_empty) begin
      grant = GRANT_FIFO;
    end
  end

  // Write port drive; a grant to register 0 is consumed without a write.
  always_comb begin
    rf_we    = 1'b0;
    rf_wreg  = '0;
    rf_wdata = '0;
    wb_stall = 1'b0;
    fifo_pop = 1'b0;
    case (grant)
      GRANT_WB: begin
        rf_we    = !is_zero_reg(wb_reg);
        rf_wreg  = wb_reg;
        rf_wdata = wb_data;
      end
      GRANT_FIFO: begin
        rf_we    = !is_zero_reg(fifo_head.rd);
        rf_wreg  = fifo_head.rd;
        rf_wdata = fifo_head.data;
        fifo_pop = 1'b1;
        wb_stall = wb_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (fifo_empty || (grant == GRANT_FIFO)) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt < STARVE_MAX) begin
      starve_cnt_nxt = starve_cnt + STARVE_CNT_W'(1);
    end
  end

  // Clear applied before set so a same-cycle reissue keeps the register busy.
  always_comb begin
    pending_nxt = pending;
    if (fifo_pop) begin
      pending_nxt[fifo_head.rd] = 1'b0;
    end
    if (issue_valid && !is_zero_reg(issue_reg)) begin
      pending_nxt[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      pending    <= pending_nxt;
    end
  end

  // Busy looks at next-state so a write landing this cycle already reads clear.
  assign busy1 = rst_n && !is_zero_reg(rd_reg1) && pending_nxt[rd_reg1];
  assign busy2 = rst_n && !is_zero_reg(rd_reg2) && pending_nxt[rd_reg2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios with a write-order scoreboard on the RF port.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_reg;
  logic [31:0] mc_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic        busy1;
  logic        busy2;
  logic        rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] sb[$];
  logic [36:0] mcq[$];
  logic [36:0] mc_src[$];

  regfile_write_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_we       (wb_we),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .wb_stall    (wb_stall),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_reg      (mc_reg),
    .mc_data     (mc_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .rd_reg1     (rd_reg1),
    .rd_reg2     (rd_reg2),
    .busy1       (busy1),
    .busy2       (busy2),
    .rf_we       (rf_we),
    .rf_wreg     (rf_wreg),
    .rf_wdata    (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we       = 1'b0;
    wb_reg      = '0;
    wb_data     = '0;
    mc_valid    = 1'b0;
    mc_reg      = '0;
    mc_data     = '0;
    issue_valid = 1'b0;
    issue_reg   = '0;
  endtask

  // Every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", 64'(rf_we), 64'(0));
      end else begin
        check("wr_order", 64'({rf_wreg, rf_wdata}), 64'(sb.pop_front()));
      end
    end
  end

  // Continuous WB stream while queued mc results are offered; masks give per-cycle expectations.
  task automatic stream(input int ncyc, input logic [31:0] stall_m,
                        input logic [31:0] ready_m, input logic [31:0] busy_m);
    logic [31:0] d;
    d = 32'h1000_0000;
    for (int k = 0; k < ncyc; k++) begin
      wb_we    = 1'b1;
      wb_reg   = 5'd10;
      wb_data  = d;
      mc_valid = (mc_src.size() != 0);
      if (mc_valid) {mc_reg, mc_data} = mc_src[0];
      if (stall_m[k]) begin
        if (mcq.size() != 0) sb.push_back(mcq.pop_front());
      end else begin
        sb.push_back({5'd10, d});
      end
      mid();
      check("stream_stall", 64'(wb_stall), 64'(stall_m[k]));
      check("stream_ready", 64'(mc_ready), 64'(ready_m[k]));
      check("stream_busy1", 64'(busy1), 64'(busy_m[k]));
      if (mc_valid && mc_ready) mcq.push_back(mc_src.pop_front());
      if (!stall_m[k]) d++;
      nxt();
    end
    wb_we    = 1'b0;
    mc_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    idle_inputs();
    rd_reg1 = '0;
    rd_reg2 = '0;

    // Reset: outputs held low even with active requests.
    wb_we = 1'b1; wb_reg = 5'd6; wb_data = 32'h6;
    issue_valid = 1'b1; issue_reg = 5'd6; rd_reg1 = 5'd6;
    mc_valid = 1'b1; mc_reg = 5'd8; mc_data = 32'h8;
    #1;
    mid();
    check("rst_rf_we", 64'(rf_we), 64'(0));
    check("rst_stall", 64'(wb_stall), 64'(0));
    check("rst_ready", 64'(mc_ready), 64'(0));
    check("rst_busy1", 64'(busy1), 64'(0));
    nxt();
    idle_inputs();
    rst_n = 1'b1;
    mid();
    check("rel_ready", 64'(mc_ready), 64'(1));
    check("rel_rf_we", 64'(rf_we), 64'(0));
    check("rel_busy1", 64'(busy1), 64'(0));
    nxt();

    // WB only.
    wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'hAAAA_5555;
    sb.push_back({5'd5, 32'hAAAA_5555});
    mid();
    check("wb_rf_we", 64'(rf_we), 64'(1));
    check("wb_wreg", 64'(rf_wreg), 64'(5));
    check("wb_wdata", 64'(rf_wdata), 64'hAAAA_5555);
    check("wb_stall0", 64'(wb_stall), 64'(0));
    nxt();
    idle_inputs();

    // Conflict: buffered result waits for a WB-idle cycle.
    mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'h12;
    mid();
    check("cf_ready", 64'(mc_ready), 64'(1));
    check("cf_nobypass", 64'(rf_we), 64'(0));
    nxt();
    mc_valid = 1'b0;
    wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'h33;
    sb.push_back({5'd3, 32'h33});
    mid();
    check("cf_wb_wreg", 64'(rf_wreg), 64'(3));
    check("cf_stall", 64'(wb_stall), 64'(0));
    nxt();
    wb_we = 1'b0;
    sb.push_back({5'd7, 32'h12});
    mid();
    check("cf_mc_wreg", 64'(rf_wreg), 64'(7));
    nxt();

    // Starvation: reg 9 forced through on the 5th cycle after its push.
    issue_valid = 1'b1; issue_reg = 5'd9; rd_reg1 = 5'd9;
    mid();
    check("st_busy_set", 64'(busy1), 64'(1));
    nxt();
    issue_valid = 1'b0;
    mc_src.push_back({5'd9, 32'h99});
    stream(7, 32'h0000_0020, 32'h0000_007F, 32'h0000_001F);
    mid();
    check("st_busy_after", 64'(busy1), 64'(0));
    nxt();

    // Full: third result accepted only after a pop freed a slot.
    rd_reg1 = '0;
    mc_src.push_back({5'd11, 32'hB1});
    mc_src.push_back({5'd12, 32'hB2});
    mc_src.push_back({5'd13, 32'hB3});
    stream(16, 32'h0000_8420, 32'h0000_F843, 32'h0000_0000);
    check("full_src_left", 64'(mc_src.size()), 64'(0));
    check("full_mcq_left", 64'(mcq.size()), 64'(0));
    mid();
    check("full_drained", 64'(rf_we), 64'(0));
    nxt();

    // Scoreboard.
    issue_valid = 1'b1; issue_reg = 5'd4; rd_reg1 = 5'd4;
    mid();
    check("sc_set", 64'(busy1), 64'(1));
    nxt();
    issue_reg = 5'd0; rd_reg2 = 5'd0;
    mid();
    check("sc_reg0", 64'(busy2), 64'(0));
    check("sc_hold", 64'(busy1), 64'(1));
    nxt();
    issue_valid = 1'b0;
    mc_valid = 1'b1; mc_reg = 5'd4; mc_data = 32'h44;
    mid();
    check("sc_wait", 64'(busy1), 64'(1));
    nxt();
    mc_valid = 1'b0;
    sb.push_back({5'd4, 32'h44});
    mid();
    check("sc_wr_we", 64'(rf_we), 64'(1));
    check("sc_clear", 64'(busy1), 64'(0));
    nxt();
    issue_valid = 1'b1; issue_reg = 5'd4;
    mc_valid = 1'b1; mc_reg = 5'd4; mc_data = 32'h45;
    mid();
    check("sc_reissue", 64'(busy1), 64'(1));
    nxt();
    mc_valid = 1'b0;
    sb.push_back({5'd4, 32'h45});
    mid();
    check("sc_setwins", 64'(busy1), 64'(1));
    nxt();
    issue_valid = 1'b0;
    mc_valid = 1'b1; mc_reg = 5'd4; mc_data = 32'h46;
    mid();
    check("sc_setheld", 64'(busy1), 64'(1));
    nxt();
    mc_valid = 1'b0;
    sb.push_back({5'd4, 32'h46});
    mid();
    check("sc_clear2", 64'(busy1), 64'(0));
    nxt();

    // Register 0 requests are consumed without writing.
    mc_valid = 1'b1; mc_reg = 5'd0; mc_data = 32'hDEAD;
    nxt();
    mc_valid = 1'b0;
    mid();
    check("r0_mc_we", 64'(rf_we), 64'(0));
    nxt();
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hBEEF;
    mc_valid = 1'b1; mc_reg = 5'd14; mc_data = 32'h14;
    mid();
    check("r0_wb_we", 64'(rf_we), 64'(0));
    check("r0_wb_stall", 64'(wb_stall), 64'(0));
    nxt();
    idle_inputs();
    sb.push_back({5'd14, 32'h14});
    mid();
    check("r0_next_wreg", 64'(rf_wreg), 64'(14));
    nxt();

    // Reset mid-operation with two buffered results.
    rd_reg1 = 5'd20;
    issue_valid = 1'b1; issue_reg = 5'd20;
    mc_valid = 1'b1; mc_reg = 5'd20; mc_data = 32'h20;
    wb_we = 1'b1; wb_reg = 5'd21; wb_data = 32'h21;
    sb.push_back({5'd21, 32'h21});
    nxt();
    issue_valid = 1'b0;
    mc_reg = 5'd22; mc_data = 32'h22;
    sb.push_back({5'd21, 32'h21});
    mid();
    check("rm_busy_pre", 64'(busy1), 64'(1));
    nxt();
    idle_inputs();
    rst_n = 1'b0;
    mid();
    check("rm_rf_we", 64'(rf_we), 64'(0));
    check("rm_busy1", 64'(busy1), 64'(0));
    check("rm_ready", 64'(mc_ready), 64'(0));
    nxt();
    rst_n = 1'b1;
    mid();
    check("rm_rel_ready", 64'(mc_ready), 64'(1));
    nxt();
    for (int i = 0; i < 6; i++) begin
      mid();
      check("rm_no_write", 64'(rf_we), 64'(0));
      check("rm_busy_post", 64'(busy1), 64'(0));
      nxt();
    end

    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
